// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants, rounding-mode codes, post-normalize FSM
//               states and status-flag bit positions for the FPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Rounding-mode encodings as presented on rmode
    localparam logic [1:0] RM_RNE  = 2'd0;
    localparam logic [1:0] RM_RZ   = 2'd1;
    localparam logic [1:0] RM_PINF = 2'd2;
    localparam logic [1:0] RM_NINF = 2'd3;

    // binary32 exponent constants
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Unnormalized fraction width and rounded mantissa width (hidden bit included)
    localparam int FRAC_W = 28;
    localparam int MANT_W = 24;

    // Post-normalize sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } pn_state_t;

    // Bit positions inside the flags vector {overflow, underflow, inexact, zero}
    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc28.sv
`default_nettype none
// ============================================================================
// Module      : fpu_lzc28
// Description : Combinational leading-zero counter over a 27-bit vector
//               (hidden bit down to the sticky bit). An all-zero input
//               reports 27.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc28 (
    input  logic [26:0] i_vec,
    output logic [4:0]  o_cnt
);

    // Scan upward so the most significant set bit is the last to write the count
    always_comb begin
        o_cnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_vec[i]) begin
                o_cnt = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_post_norm.sv
`default_nettype none
// ============================================================================
// Module      : fpu_post_norm
// Description : Add/sub result stage. Normalizes a 28-bit unnormalized
//               fraction, rounds it under the captured rounding mode, packs
//               a binary32 result and raises {ovf, unf, inexact, zero}.
//               Four-state sequencer with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_post_norm #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [1:0]        rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out,
    output logic [3:0]        flags
);
    import fpu_pkg::*;

    // Exponent carries one spare bit so carries out of normalize/round are visible
    localparam logic [EXP_W:0] c_exp_one = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] c_exp_max = (EXP_W+1)'(EXP_MAX);

    pn_state_t         r_state;
    logic              r_sign;
    logic [EXP_W:0]    r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic [1:0]        r_rmode;

    logic [4:0]        w_lzc;
    logic [EXP_W:0]    w_norm_exp;
    logic [FRAC_W-1:0] w_norm_frac;

    logic [MANT_W-1:0] w_mant;
    logic              w_inexact;
    logic              w_inc;
    logic [MANT_W:0]   w_sum;
    logic [MANT_W-1:0] w_mant_r;
    logic [EXP_W:0]    w_exp_r;
    logic              w_ovf;
    logic              w_to_inf;
    logic [31:0]       w_out;
    logic [3:0]        w_flags;

    fpu_lzc28 u_lzc (
        .i_vec (r_frac[FRAC_W-2:0]),
        .o_cnt (w_lzc)
    );

    // Normalize: right shift on carry, else left shift clamped so the exponent stops at 0
    always_comb begin
        w_norm_exp  = r_exp;
        w_norm_frac = r_frac;
        if (r_frac == '0) begin
            w_norm_exp  = '0;
            w_norm_frac = '0;
        end else if (r_frac[FRAC_W-1]) begin
            w_norm_frac = {1'b0, r_frac[FRAC_W-1:2], r_frac[1] | r_frac[0]};
            w_norm_exp  = r_exp + c_exp_one;
        end else if (r_exp > {{(EXP_W-4){1'b0}}, w_lzc}) begin
            w_norm_frac = r_frac << w_lzc;
            w_norm_exp  = r_exp - {{(EXP_W-4){1'b0}}, w_lzc};
        end else if (r_exp != '0) begin
            w_norm_frac = r_frac << (r_exp - c_exp_one);
            w_norm_exp  = '0;
        end
    end

    // Round, handle mantissa carry and denormal promotion, saturate on overflow, pack
    always_comb begin
        w_mant    = r_frac[FRAC_W-2:3];
        w_inexact = |r_frac[2:0];
        case (r_rmode)
            RM_RNE:  w_inc = r_frac[2] & (r_frac[1] | r_frac[0] | w_mant[0]);
            RM_RZ:   w_inc = 1'b0;
            RM_PINF: w_inc = w_inexact & ~r_sign;
            default: w_inc = w_inexact & r_sign;
        endcase
        w_sum = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_inc};
        if (w_sum[MANT_W]) begin
            w_mant_r = w_sum[MANT_W:1];
            w_exp_r  = r_exp + c_exp_one;
        end else begin
            w_mant_r = w_sum[MANT_W-1:0];
            w_exp_r  = r_exp;
        end
        // A denormal that rounded up into the hidden bit becomes the smallest normal
        if ((w_exp_r == '0) && w_mant_r[MANT_W-1]) begin
            w_exp_r = c_exp_one;
        end
        w_ovf    = (w_exp_r >= c_exp_max);
        w_to_inf = (r_rmode == RM_RNE) ||
                   ((r_rmode == RM_PINF) && !r_sign) ||
                   ((r_rmode == RM_NINF) && r_sign);
        if (w_ovf) begin
            w_out = w_to_inf ? {r_sign, 31'h7F80_0000} : {r_sign, 31'h7F7F_FFFF};
        end else begin
            w_out = {r_sign, w_exp_r[EXP_W-1:0], w_mant_r[MANT_W-2:0]};
        end
        w_flags            = '0;
        w_flags[FLAG_OVF]  = w_ovf;
        w_flags[FLAG_UNF]  = (w_exp_r == '0) & w_inexact;
        w_flags[FLAG_INX]  = w_inexact | w_ovf;
        w_flags[FLAG_ZERO] = (w_out[30:0] == 31'd0);
    end

    // Sequencer: capture, normalize, round/pack, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_frac    <= '0;
            r_rmode   <= RM_RNE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign   <= in_sign;
                        r_exp    <= {1'b0, in_exp};
                        r_frac   <= in_frac;
                        r_rmode  <= rmode;
                        in_ready <= 1'b0;
                        r_state  <= NORM;
                    end
                end
                NORM: begin
                    r_exp   <= w_norm_exp;
                    r_frac  <= w_norm_frac;
                    r_state <= ROUND;
                end
                ROUND: begin
                    out       <= w_out;
                    flags     <= w_flags;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_post_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_post_norm
// Description : Self-checking bench for fpu_post_norm. Directed corner
//               cases plus randomized bundles against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_post_norm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_frac;
    logic [1:0]  rmode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    fpu_post_norm #(.EXP_W(8), .FRAC_W(28)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_frac   (in_frac),
        .rmode     (rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Value-level model: normalize by repeated single shifts, round with integer remainders
    function automatic logic [35:0] ref_model(input logic s, input logic [7:0] e_in,
                                              input logic [27:0] f_in, input logic [1:0] rm);
        longint      f;
        longint      mant;
        longint      rem;
        int          ee;
        logic        inc;
        logic        inex;
        logic        ovf;
        logic        unf;
        logic        zr;
        logic [31:0] res;
        f  = longint'(f_in);
        ee = int'(e_in);
        if (f == 0) begin
            ee = 0;
        end else if (f >= (longint'(1) << 27)) begin
            f  = (f >> 1) | (f & 1);
            ee = ee + 1;
        end else begin
            while (f < (longint'(1) << 26) && ee > 1) begin
                f  = f << 1;
                ee = ee - 1;
            end
            if (f < (longint'(1) << 26) && ee == 1) ee = 0;
        end
        mant = f >> 3;
        rem  = f & 7;
        inex = (rem != 0);
        case (rm)
            2'd0:    inc = (rem > 4) || (rem == 4 && mant[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = inex && !s;
            default: inc = inex && s;
        endcase
        mant = mant + longint'(inc);
        if (mant >= (longint'(1) << 24)) begin
            mant = mant >> 1;
            ee   = ee + 1;
        end
        if (ee == 0 && mant >= (longint'(1) << 23)) ee = 1;
        ovf = (ee >= 255);
        if (ovf) begin
            inex = 1'b1;
            if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) res = {s, 31'h7F80_0000};
            else res = {s, 31'h7F7F_FFFF};
        end else begin
            res = {s, ee[7:0], mant[22:0]};
        end
        unf = (ee == 0) && inex;
        zr  = (res[30:0] == 31'd0);
        return {res, ovf, unf, inex, zr};
    endfunction

    // Push one bundle, optionally stall the consumer, then take the result
    task automatic apply(input logic s, input logic [7:0] e, input logic [27:0] f,
                         input logic [1:0] rm, input int hold, input bit use_fixed,
                         input logic [35:0] fixed, input bit chk_lat, input string tag);
        logic [35:0] want;
        int          k;
        int          lat;
        want = use_fixed ? fixed : ref_model(s, e, f, rm);
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_frac  = f;
        rmode    = rm;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rmode    = ~rm;
        in_sign  = ~s;
        chk({tag, ".busy"}, 36'(in_ready), 36'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) chk({tag, ".latency"}, 36'(lat), 36'd3);
        chk({tag, ".valid"}, 36'(out_valid), 36'd1);
        chk({tag, ".out"}, 36'(out), 36'(want[35:4]));
        chk({tag, ".flags"}, 36'(flags), 36'(want[3:0]));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_frac  = 28'($urandom);
            in_exp   = 8'($urandom);
            @(negedge clk);
            chk({tag, ".hold_out"}, 36'(out), 36'(want[35:4]));
            chk({tag, ".hold_flags"}, 36'(flags), 36'(want[3:0]));
            chk({tag, ".hold_valid"}, 36'(out_valid), 36'd1);
            chk({tag, ".hold_ready"}, 36'(in_ready), 36'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drop"}, 36'(out_valid), 36'd0);
        chk({tag, ".ready"}, 36'(in_ready), 36'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_frac   = '0;
        rmode     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.in_ready", 36'(in_ready), 36'd1);
        chk("reset.out_valid", 36'(out_valid), 36'd0);
        chk("reset.out", 36'(out), 36'd0);
        chk("reset.flags", 36'(flags), 36'd0);
        rst = 1'b0;

        apply(1'b0, 8'd127, 28'h8000000, 2'd0, 0, 1'b1, {32'h4000_0000, 4'b0000}, 1'b1, "carry");
        apply(1'b0, 8'd127, 28'h0800000, 2'd0, 0, 1'b1, {32'h3E00_0000, 4'b0000}, 1'b1, "lnorm");
        apply(1'b0, 8'd127, 28'h4000004, 2'd0, 0, 1'b1, {32'h3F80_0000, 4'b0010}, 1'b0, "tie_even");
        apply(1'b0, 8'd127, 28'h400000C, 2'd0, 0, 1'b1, {32'h3F80_0002, 4'b0010}, 1'b0, "tie_up");
        apply(1'b0, 8'd127, 28'h400000C, 2'd1, 0, 1'b1, {32'h3F80_0001, 4'b0010}, 1'b0, "rz");
        apply(1'b0, 8'd254, 28'h8000000, 2'd0, 0, 1'b1, {32'h7F80_0000, 4'b1010}, 1'b0, "ovf_rne");
        apply(1'b0, 8'd254, 28'h8000000, 2'd1, 0, 1'b1, {32'h7F7F_FFFF, 4'b1010}, 1'b0, "ovf_rz");
        apply(1'b1, 8'd254, 28'h8000000, 2'd2, 5, 1'b1, {32'hFF7F_FFFF, 4'b1010}, 1'b0, "ovf_pinf_neg");
        apply(1'b1, 8'd100, 28'h0000000, 2'd0, 0, 1'b1, {32'h8000_0000, 4'b0001}, 1'b0, "zero");
        apply(1'b0, 8'd2,   28'h0800000, 2'd0, 0, 1'b0, '0, 1'b0, "denorm");

        // Reset while the bundle sits in ROUND: result must never appear
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_frac  = 28'h8000000;
        rmode    = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_round.out_valid", 36'(out_valid), 36'd0);
        chk("rst_round.in_ready", 36'(in_ready), 36'd1);
        chk("rst_round.out", 36'(out), 36'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_round.no_stale", 36'(out_valid), 36'd0);

        apply(1'b1, 8'd130, 28'h0123457, 2'd3, 0, 1'b0, '0, 1'b1, "post_rst");

        for (int i = 0; i < 300; i++) begin
            logic [27:0] f;
            logic [7:0]  e;
            int          sel;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       f = 28'($urandom);
                1:       f = 28'($urandom) >> $urandom_range(0, 27);
                2:       f = 28'd0;
                3:       f = {1'($urandom_range(0, 1)), 24'hFF_FFFF, 3'($urandom_range(0, 7))};
                default: f = 28'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 1) == 1) e = 8'($urandom);
            else if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(0, 3));
            else e = 8'($urandom_range(250, 255));
            apply(1'($urandom), e, f, 2'($urandom), int'($urandom_range(0, 2)), 1'b0, '0, 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
